// File: rtl/median_window_gen.sv
// Streaming 3x3 window generator over a circular line buffer, feeding the median-9 network.
// Optional macro WINGEN_BORDER_REPLICATE_EN: border windows use edge-replicated taps.
module median_window_gen #(
   parameter int unsigned MAX_WIDTH  = 512,
   parameter int unsigned MAX_HEIGHT = 512,
   parameter int unsigned DATA_W     = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic [$clog2(MAX_WIDTH+1)-1:0]     width,
   input  logic [$clog2(MAX_HEIGHT+1)-1:0]    height,
   input  logic                               s_valid,
   output logic                               s_ready,
   input  logic [DATA_W-1:0]                  s_data,
   output logic                               m_valid,
   input  logic                               m_ready,
   output logic [9*DATA_W-1:0]                m_win,
   output logic                               m_border,
   output logic                               done,
   output logic                               err
);
   localparam int unsigned WidthW  = $clog2(MAX_WIDTH+1);
   localparam int unsigned HeightW = $clog2(MAX_HEIGHT+1);
   localparam int unsigned CntW    = $clog2(MAX_WIDTH*MAX_HEIGHT+1);
   localparam int unsigned CmpW    = CntW + 2;
   localparam int unsigned Depth   = 2*MAX_WIDTH + 4;
   localparam int unsigned AddrW   = $clog2(Depth);
   localparam int unsigned TmpW    = AddrW + 2;

   localparam logic [WidthW-1:0]  MaxW     = WidthW'(MAX_WIDTH);
   localparam logic [HeightW-1:0] MaxH     = HeightW'(MAX_HEIGHT);
   localparam logic [AddrW-1:0]   LastAddr = AddrW'(Depth - 1);
   localparam logic [TmpW-1:0]    DepthT   = TmpW'(Depth);
   localparam logic [TmpW-1:0]    Depth2T  = TmpW'(2*Depth);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e               state_q, state_d;
   logic [WidthW-1:0]    w_q, w_d, col_q, col_d;
   logic [HeightW-1:0]   h_q, h_d, row_q, row_d;
   logic [CntW-1:0]      n_q, n_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
   logic [AddrW-1:0]     wr_ptr_q, wr_ptr_d, ctr_q, ctr_d;
   logic                 m_valid_q, m_valid_d, m_border_q, m_border_d;
   logic [9*DATA_W-1:0]  m_win_q, m_win_d;
   logic                 done_q, done_d, err_q, err_d;
   logic [DATA_W-1:0]    mem_q [Depth];

   logic                 size_ok, clr, accept, load;
   logic                 at_top, at_bot, at_left, at_right, border;
   logic [CmpW-1:0]      lag, w_plus2, in_cnt_nx, need, thr;
   logic [AddrW-1:0]     tap_addr [9];
   logic [DATA_W-1:0]    tap_val [9];
   logic [9*DATA_W-1:0]  win;

   assign size_ok = (width != '0) && (width <= MaxW) && (height != '0) && (height <= MaxH);

   assign lag     = CmpW'(in_cnt_q) - CmpW'(out_cnt_q);
   assign w_plus2 = CmpW'(w_q) + CmpW'(2);
   assign s_ready = (state_q == StRun) && (in_cnt_q < n_q) && (lag <= w_plus2);
   assign accept  = s_valid && s_ready;

   // Load may use the pixel accepted on the same edge; the tap mux bypasses it from s_data.
   assign in_cnt_nx = CmpW'(in_cnt_q) + CmpW'(accept);
   assign need      = CmpW'(out_cnt_q) + w_plus2;
   assign thr       = (need > CmpW'(n_q)) ? CmpW'(n_q) : need;
   assign load      = (state_q == StRun) && (out_cnt_q < n_q) && (!m_valid_q || m_ready) &&
                      (in_cnt_nx >= thr);

   assign at_top   = (row_q == '0);
   assign at_bot   = (row_q == h_q - HeightW'(1));
   assign at_left  = (col_q == '0);
   assign at_right = (col_q == w_q - WidthW'(1));
   assign border   = at_top || at_bot || at_left || at_right;

   always_comb begin
      logic          up, dn, lf, rt;
      logic [TmpW-1:0] t;
      up  = 1'b0;
      dn  = 1'b0;
      lf  = 1'b0;
      rt  = 1'b0;
      t   = '0;
      win = '0;
      for (int k = 0; k < 9; k++) begin
`ifdef WINGEN_BORDER_REPLICATE_EN
         up = (k < 3) && !at_top;
         dn = (k >= 6) && !at_bot;
         lf = (k % 3 == 0) && !at_left;
         rt = (k % 3 == 2) && !at_right;
`else
         up = (k < 3);
         dn = (k >= 6);
         lf = (k % 3 == 0);
         rt = (k % 3 == 2);
`endif
         // Bias by Depth so the offset never goes negative, then fold back at most twice.
         t = TmpW'(ctr_q) + DepthT;
         if (dn) t = t + TmpW'(w_q);
         if (rt) t = t + TmpW'(1);
         if (up) t = t - TmpW'(w_q);
         if (lf) t = t - TmpW'(1);
         if (t >= Depth2T) t = t - Depth2T;
         else if (t >= DepthT) t = t - DepthT;
         tap_addr[k] = AddrW'(t);
         tap_val[k]  = (accept && (tap_addr[k] == wr_ptr_q)) ? s_data : mem_q[tap_addr[k]];
      end
      for (int k = 0; k < 9; k++) begin
`ifdef WINGEN_BORDER_REPLICATE_EN
         win[DATA_W*k +: DATA_W] = tap_val[k];
`else
         win[DATA_W*k +: DATA_W] = border ? tap_val[4] : tap_val[k];
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      h_d     = h_q;
      n_d     = n_q;
      done_d  = done_q;
      err_d   = err_q;
      clr     = 1'b0;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               done_d = 1'b0;
               if (size_ok) begin
                  state_d = StRun;
                  w_d     = width;
                  h_d     = height;
                  n_d     = CntW'(width) * CntW'(height);
                  err_d   = 1'b0;
                  clr     = 1'b1;
               end else begin
                  state_d = StIdle;
                  err_d   = 1'b1;
               end
            end
         end
         StRun: begin
            if (m_valid_q && m_ready && (out_cnt_q == n_q)) begin
               state_d = StDone;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      in_cnt_d   = in_cnt_q;
      out_cnt_d  = out_cnt_q;
      wr_ptr_d   = wr_ptr_q;
      ctr_d      = ctr_q;
      row_d      = row_q;
      col_d      = col_q;
      m_valid_d  = m_valid_q;
      m_win_d    = m_win_q;
      m_border_d = m_border_q;
      if (clr) begin
         in_cnt_d  = '0;
         out_cnt_d = '0;
         wr_ptr_d  = '0;
         ctr_d     = '0;
         row_d     = '0;
         col_d     = '0;
         m_valid_d = 1'b0;
      end else begin
         if (accept) begin
            in_cnt_d = in_cnt_q + CntW'(1);
            wr_ptr_d = (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + AddrW'(1);
         end
         if (load) begin
            out_cnt_d  = out_cnt_q + CntW'(1);
            ctr_d      = (ctr_q == LastAddr) ? '0 : ctr_q + AddrW'(1);
            m_valid_d  = 1'b1;
            m_win_d    = win;
            m_border_d = border;
            if (at_right) begin
               col_d = '0;
               row_d = row_q + HeightW'(1);
            end else begin
               col_d = col_q + WidthW'(1);
            end
         end else if (m_ready) begin
            m_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         w_q        <= '0;
         h_q        <= '0;
         n_q        <= '0;
         in_cnt_q   <= '0;
         out_cnt_q  <= '0;
         wr_ptr_q   <= '0;
         ctr_q      <= '0;
         row_q      <= '0;
         col_q      <= '0;
         m_valid_q  <= 1'b0;
         m_win_q    <= '0;
         m_border_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         w_q        <= w_d;
         h_q        <= h_d;
         n_q        <= n_d;
         in_cnt_q   <= in_cnt_d;
         out_cnt_q  <= out_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         ctr_q      <= ctr_d;
         row_q      <= row_d;
         col_q      <= col_d;
         m_valid_q  <= m_valid_d;
         m_win_q    <= m_win_d;
         m_border_q <= m_border_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   // Pixel storage carries no reset; stale entries are never read before being rewritten.
   always_ff @(posedge clk) begin
      if (accept) mem_q[wr_ptr_q] <= s_data;
   end

   assign m_valid  = m_valid_q;
   assign m_win    = m_win_q;
   assign m_border = m_border_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_median_window_gen.sv
// Scoreboard bench for median_window_gen: a coordinate-based window model feeds an expected queue.
module tb_median_window_gen;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [9:0]  width = '0;
   logic [9:0]  height = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [7:0]  s_data = '0;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic [71:0] m_win;
   logic        m_border;
   logic        done;
   logic        err;

   int          checks = 0;
   int          errors = 0;
   logic [72:0] exp_q[$];
   logic [7:0]  pix [64];
   logic [71:0] win_log [64];
   logic        border_log [64];
   int          in_acc = 0;
   int          out_acc = 0;
   int          cur_w = 1;
   bit          stall_en = 1'b0;

   median_window_gen #(.MAX_WIDTH(512), .MAX_HEIGHT(512), .DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .width(width), .height(height),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_win(m_win), .m_border(m_border),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Downstream: always ready, or ready one cycle in three when stalling.
   initial begin
      int cyc = 0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         m_ready = stall_en ? (cyc % 3 == 0) : 1'b1;
      end
   end

   function automatic logic [72:0] model(input int w, input int h, input int n);
      int r = n / w;
      int c = n % w;
      int rr, cc;
      bit brd;
      logic [71:0] wv = '0;
      brd = (r == 0) || (r == h - 1) || (c == 0) || (c == w - 1);
      for (int dy = -1; dy <= 1; dy++) begin
         for (int dx = -1; dx <= 1; dx++) begin
`ifdef WINGEN_BORDER_REPLICATE_EN
            rr = (r + dy < 0) ? 0 : (r + dy > h - 1) ? h - 1 : r + dy;
            cc = (c + dx < 0) ? 0 : (c + dx > w - 1) ? w - 1 : c + dx;
`else
            rr = brd ? r : r + dy;
            cc = brd ? c : c + dx;
`endif
            wv[8*(3*(dy+1)+dx+1) +: 8] = pix[rr*w+cc];
         end
      end
      return {brd, wv};
   endfunction

   // Monitor: pops the scoreboard on each accepted window, checks hold and the lag bound.
   initial begin
      logic [71:0] held_win;
      logic        held_brd;
      logic [72:0] e;
      bit          held = 1'b0;
      held_win = '0;
      held_brd = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            held = 1'b0;
         end else if (start) begin
            in_acc  = 0;
            out_acc = 0;
            held    = 1'b0;
         end else begin
            if (held) begin
               checks++;
               if (m_valid !== 1'b1 || m_win !== held_win || m_border !== held_brd) begin
                  errors++;
                  $display("FAIL hold got v=%b %h/%b exp v=1 %h/%b", m_valid, m_win, m_border,
                           held_win, held_brd);
               end
            end
            if (s_ready) begin
               checks++;
               if (in_acc - out_acc - int'(m_valid) > cur_w + 2) begin
                  errors++;
                  $display("FAIL lag got %0d exp <= %0d", in_acc - out_acc - int'(m_valid),
                           cur_w + 2);
               end
            end
            if (s_valid && s_ready) in_acc++;
            held     = m_valid && !m_ready;
            held_win = m_win;
            held_brd = m_border;
            if (m_valid && m_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL extra_window got %h/%b exp none", m_win, m_border);
               end else begin
                  e = exp_q.pop_front();
                  if ({m_border, m_win} !== e) begin
                     errors++;
                     $display("FAIL window_%0d got %h/%b exp %h/%b", out_acc, m_win, m_border,
                              e[71:0], e[72]);
                  end
               end
               if (out_acc < 64) begin
                  win_log[out_acc]    = m_win;
                  border_log[out_acc] = m_border;
               end
               out_acc++;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

   task automatic pulse_start(input int w, input int h);
      @(posedge clk);
      #1;
      width  = 10'(w);
      height = 10'(h);
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
   endtask

   task automatic drive_pixels(input int count, input bit gaps, output bit tmo);
      int  i = 0;
      int  guard = 0;
      bit  acc;
      tmo = 1'b0;
      while (i < count) begin
         s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         s_data  = pix[i];
         @(negedge clk);
         acc = s_valid && s_ready;
         @(posedge clk);
         #1;
         if (acc) i++;
         guard++;
         if (guard > 5000) begin
            tmo = 1'b1;
            break;
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic run_frame(input int w, input int h, input bit gaps, output bit tmo,
                            output logic rdy0);
      int g = 0;
      cur_w = w;
      for (int n = 0; n < w * h; n++) exp_q.push_back(model(w, h, n));
      pulse_start(w, h);
      @(negedge clk);
      rdy0 = s_ready;
      @(posedge clk);
      #1;
      drive_pixels(w * h, gaps, tmo);
      while (!done && g < 3000) begin
         @(negedge clk);
         g++;
      end
      if (!done) tmo = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks += 6;
      if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready got %b exp 0", s_ready); end
      if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got %b exp 0", m_valid); end
      if (m_win !== '0) begin errors++; $display("FAIL rst_m_win got %h exp 0", m_win); end
      if (m_border !== 1'b0) begin errors++; $display("FAIL rst_border got %b exp 0", m_border); end
      if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
      if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
      rst_n = 1'b1;
   endtask

   task automatic test_ramp4x4();
      bit tmo;
      logic rdy0;
      logic [71:0] w5;
      w5 = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
      for (int i = 0; i < 16; i++) pix[i] = 8'(i);
      run_frame(4, 4, 1'b0, tmo, rdy0);
      checks += 7;
      if (tmo) begin errors++; $display("FAIL ramp_timeout got 1 exp 0"); end
      if (rdy0 !== 1'b1) begin errors++; $display("FAIL ramp_ready got %b exp 1", rdy0); end
      if (out_acc != 16 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL ramp_count got %0d/%0d exp 16/0", out_acc, exp_q.size());
      end
      if (done !== 1'b1) begin errors++; $display("FAIL ramp_done got %b exp 1", done); end
      if (win_log[5] !== w5 || border_log[5] !== 1'b0) begin
         errors++;
         $display("FAIL ramp_win5 got %h/%b exp %h/0", win_log[5], border_log[5], w5);
      end
`ifndef WINGEN_BORDER_REPLICATE_EN
      if (win_log[0] !== '0 || border_log[0] !== 1'b1) begin
         errors++;
         $display("FAIL ramp_win0 got %h/%b exp 0/1", win_log[0], border_log[0]);
      end
`else
      if (border_log[0] !== 1'b1) begin
         errors++;
         $display("FAIL ramp_win0 got %b exp 1", border_log[0]);
      end
`endif
      if (s_ready !== 1'b0) begin errors++; $display("FAIL ramp_idle got %b exp 0", s_ready); end
   endtask

   task automatic test_random_stall();
      bit tmo;
      logic rdy0;
      for (int i = 0; i < 48; i++) pix[i] = 8'($urandom);
      for (int pass = 0; pass < 2; pass++) begin
         stall_en = (pass == 1);
         run_frame(8, 6, 1'b1, tmo, rdy0);
         checks += 3;
         if (tmo) begin errors++; $display("FAIL rand_timeout_%0d got 1 exp 0", pass); end
         if (out_acc != 48 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_count_%0d got %0d/%0d exp 48/0", pass, out_acc, exp_q.size());
         end
         if (done !== 1'b1) begin errors++; $display("FAIL rand_done_%0d got %b exp 1", pass, done); end
      end
      stall_en = 1'b0;
   endtask

   task automatic test_1x1();
      bit tmo;
      logic rdy0;
      pix[0] = 8'hA5;
      run_frame(1, 1, 1'b0, tmo, rdy0);
      checks += 3;
      if (tmo || out_acc != 1) begin
         errors++;
         $display("FAIL one_count got %0d tmo=%b exp 1 tmo=0", out_acc, tmo);
      end
      if (win_log[0] !== {9{8'hA5}} || border_log[0] !== 1'b1) begin
         errors++;
         $display("FAIL one_win got %h/%b exp %h/1", win_log[0], border_log[0], {9{8'hA5}});
      end
      if (done !== 1'b1) begin errors++; $display("FAIL one_done got %b exp 1", done); end
   endtask

   task automatic test_illegal();
      bit tmo;
      logic rdy0;
      int bad_w [2];
      bad_w[0] = 0;
      bad_w[1] = 513;
      for (int i = 0; i < 2; i++) begin
         pulse_start(bad_w[i], 4);
         @(negedge clk);
         checks += 3;
         if (err !== 1'b1) begin errors++; $display("FAIL bad_err_%0d got %b exp 1", i, err); end
         if (s_ready !== 1'b0) begin errors++; $display("FAIL bad_rdy_%0d got %b exp 0", i, s_ready); end
         if (done !== 1'b0) begin errors++; $display("FAIL bad_done_%0d got %b exp 0", i, done); end
         @(negedge clk);
         checks++;
         if (s_ready !== 1'b0) begin errors++; $display("FAIL bad_rdy2_%0d got %b exp 0", i, s_ready); end
      end
      for (int i = 0; i < 4; i++) pix[i] = 8'(8'h30 + i);
      run_frame(2, 2, 1'b0, tmo, rdy0);
      checks += 2;
      if (err !== 1'b0) begin errors++; $display("FAIL good_err got %b exp 0", err); end
      if (tmo || out_acc != 4 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL good_count got %0d/%0d exp 4/0", out_acc, exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      bit tmo;
      logic rdy0;
      for (int i = 0; i < 25; i++) pix[i] = 8'($urandom);
      cur_w = 5;
      for (int n = 0; n < 25; n++) exp_q.push_back(model(5, 5, n));
      pulse_start(5, 5);
      drive_pixels(10, 1'b0, tmo);
      #2;
      rst_n = 1'b0;
      #1;
      checks += 6;
      if (s_ready !== 1'b0) begin errors++; $display("FAIL mid_s_ready got %b exp 0", s_ready); end
      if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_m_valid got %b exp 0", m_valid); end
      if (m_win !== '0) begin errors++; $display("FAIL mid_m_win got %h exp 0", m_win); end
      if (m_border !== 1'b0) begin errors++; $display("FAIL mid_border got %b exp 0", m_border); end
      if (done !== 1'b0) begin errors++; $display("FAIL mid_done got %b exp 0", done); end
      if (err !== 1'b0) begin errors++; $display("FAIL mid_err got %b exp 0", err); end
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0) begin errors++; $display("FAIL mid_nostart got %b exp 0", s_ready); end
      run_frame(5, 5, 1'b1, tmo, rdy0);
      checks += 2;
      if (tmo || out_acc != 25 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL mid_count got %0d/%0d exp 25/0", out_acc, exp_q.size());
      end
      if (done !== 1'b1) begin errors++; $display("FAIL mid_done2 got %b exp 1", done); end
   endtask

`ifdef WINGEN_BORDER_REPLICATE_EN
   task automatic test_replicate();
      bit tmo;
      logic rdy0;
      logic [71:0] w0;
      logic [71:0] w4;
      w0 = {8'd5, 8'd4, 8'd4, 8'd2, 8'd1, 8'd1, 8'd2, 8'd1, 8'd1};
      w4 = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
      for (int i = 0; i < 9; i++) pix[i] = 8'(i + 1);
      run_frame(3, 3, 1'b0, tmo, rdy0);
      checks += 3;
      if (tmo || out_acc != 9) begin errors++; $display("FAIL rep_count got %0d exp 9", out_acc); end
      if (win_log[0] !== w0 || border_log[0] !== 1'b1) begin
         errors++;
         $display("FAIL rep_win0 got %h/%b exp %h/1", win_log[0], border_log[0], w0);
      end
      if (win_log[4] !== w4 || border_log[4] !== 1'b0) begin
         errors++;
         $display("FAIL rep_win4 got %h/%b exp %h/0", win_log[4], border_log[4], w4);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_ramp4x4();
      test_random_stall();
      test_1x1();
      test_illegal();
      test_reset_mid();
`ifdef WINGEN_BORDER_REPLICATE_EN
      test_replicate();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
